// File: rtl/ram8_arb_pkg.sv
// Shared types and default widths for the RAM8 arbiter/sequencer.
// The state encoding is fixed so that an unused code (2'd3) can be recovered.
package ram8_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/ram8_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// and on contention the port named by the pointer wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic grant_valid,
    output logic grant_idx
);

    logic w_both;

    assign w_both      = req0 & req1;
    assign grant_valid = req0 | req1;
    assign grant_idx   = w_both ? pointer : req1;

endmodule

// File: rtl/ram8_arbiter.sv
// Shares one RAM8 between a CPU port (0) and a loader port (1): one transaction
// at a time, IDLE -> ACCESS (RAM drive) -> RESP (ack + read data) -> IDLE.
module ram8_arbiter
    import ram8_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_sel,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy,
    output logic              gnt
);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_ptr;
    logic                r_gnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_ack0;
    logic                r_ack1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                w_grant_valid;
    logic                w_grant_idx;
    logic [DATA_W-1:0]   w_resp_data;

    rr_arb2 u_rr_arb2 (
        .req0        (req0),
        .req1        (req1),
        .pointer     (r_ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // A write answers with the word just stored; the RAM's combinational out
    // still shows the old contents until the write edge has passed.
    assign w_resp_data = r_we ? r_wdata : ram_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr    <= 1'b0;
            r_gnt    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_gnt   <= w_grant_idx;
                        r_we    <= w_grant_idx ? we1    : we0;
                        r_addr  <= w_grant_idx ? addr1  : addr0;
                        r_wdata <= w_grant_idx ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    if (r_gnt) begin
                        r_rdata1 <= w_resp_data;
                        r_ack1   <= 1'b1;
                    end else begin
                        r_rdata0 <= w_resp_data;
                        r_ack0   <= 1'b1;
                    end
                end
                RESP: begin
                    r_ptr <= ~r_gnt;
                end
                default: begin
                end
            endcase
        end
    end

    // Gating with rst_n keeps a reset asserted during ACCESS from committing the write.
    assign ram_load = (r_state == ACCESS) && r_we && rst_n;
    assign ram_sel  = r_addr;
    assign ram_in   = r_wdata;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign busy     = (r_state != IDLE);
    assign gnt      = r_gnt;

    a_ack_excl: assert property (@(posedge clk) disable iff (!rst_n) !(ack0 && ack1));
    a_load_access: assert property (@(posedge clk) disable iff (!rst_n) ram_load |-> (r_state == ACCESS));

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter with a behavioural RAM8 (combinational read,
// write on the clock edge when load is high).
module tb_ram8_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] ram_in;
    logic [2:0]  ram_sel;
    logic        ram_load;
    logic [15:0] ram_out;
    logic        busy, gnt;

    logic [15:0] mem [0:7];
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ram_out = mem[ram_sel];
    always @(posedge clk) if (ram_load) mem[ram_sel] <= ram_in;

    ram8_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .ram_in(ram_in), .ram_sel(ram_sel), .ram_load(ram_load), .ram_out(ram_out),
        .busy(busy), .gnt(gnt)
    );

    // Issues one transaction from the IDLE cycle and waits (bounded) for its ack.
    task automatic run_txn(input int port, input logic we, input logic [2:0] addr,
                           input logic [15:0] wd, output logic [15:0] rd, output int lat,
                           output int loads, output logic [2:0] lsel, output logic [15:0] lin,
                           output int other_ack, output logic ack_after, output int ack_cyc);
        rd = '0; lat = -1; loads = 0; lsel = '0; lin = '0; other_ack = 0; ack_after = 1'b1; ack_cyc = -1;
        if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
        else begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (ram_load === 1'b1) begin loads++; lsel = ram_sel; lin = ram_in; end
            if (((port == 0) ? ack1 : ack0) === 1'b1) other_ack++;
            if (((port == 0) ? ack0 : ack1) === 1'b1) begin
                lat = n; ack_cyc = cyc; rd = (port == 0) ? rdata0 : rdata1;
                break;
            end
        end
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
        @(posedge clk); #1;
        ack_after = (port == 0) ? ack0 : ack1;
    endtask

    task automatic test_reset();
        logic seen;
        rst_n = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; wdata0 = 16'h1234;
        req1 = 1'b0; we1 = 1'b0; addr1 = 3'd0; wdata1 = 16'h0;
        repeat (2) begin
            @(posedge clk); #1;
            total_cnt++;
            if ({ram_load, ack0, ack1, busy, gnt} !== 5'b0 || ram_sel !== 3'd0 || ram_in !== 16'h0 ||
                rdata0 !== 16'h0 || rdata1 !== 16'h0)
                $display("FAIL reset_outputs got load=%b ack=%b%b busy=%b gnt=%b sel=%h in=%h rd0=%h rd1=%h exp all 0",
                         ram_load, ack0, ack1, busy, gnt, ram_sel, ram_in, rdata0, rdata1);
            else pass_cnt++;
        end
        total_cnt++;
        if (mem[3] !== 16'h0) $display("FAIL reset_no_write got mem3=%h exp 0000", mem[3]);
        else pass_cnt++;
        rst_n = 1'b1; req0 = 1'b0; we0 = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || ram_load !== 1'b0) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL idle_stays_idle got activity=%b exp 0", seen);
        else pass_cnt++;
        $display("reset: done, %0d/%0d so far", pass_cnt, total_cnt);
    endtask

    task automatic test_p0_write_read();
        logic [15:0] rd; int lat, loads, oth, ac; logic [2:0] ls; logic [15:0] li; logic aa;
        run_txn(0, 1'b1, 3'd3, 16'h4444, rd, lat, loads, ls, li, oth, aa, ac);
        $display("p0 write addr=3 data=4444 lat=%0d loads=%0d sel=%0d in=%h rd=%h", lat, loads, ls, li, rd);
        total_cnt++;
        if (lat !== 2) $display("FAIL p0_write_latency got=%0d exp=2", lat); else pass_cnt++;
        total_cnt++;
        if (loads !== 1 || ls !== 3'd3 || li !== 16'h4444)
            $display("FAIL p0_write_ram_drive got loads=%0d sel=%0d in=%h exp 1/3/4444", loads, ls, li);
        else pass_cnt++;
        total_cnt++;
        if (rd !== 16'h4444 || aa !== 1'b0 || oth !== 0)
            $display("FAIL p0_write_resp got rd=%h ack_after=%b other=%0d exp 4444/0/0", rd, aa, oth);
        else pass_cnt++;
        run_txn(0, 1'b0, 3'd3, 16'h0000, rd, lat, loads, ls, li, oth, aa, ac);
        $display("p0 read addr=3 lat=%0d loads=%0d rd=%h", lat, loads, rd);
        total_cnt++;
        if (rd !== 16'h4444 || loads !== 0 || lat !== 2)
            $display("FAIL p0_read got rd=%h loads=%0d lat=%0d exp 4444/0/2", rd, loads, lat);
        else pass_cnt++;
    endtask

    task automatic test_fill_verify();
        logic [15:0] rd, v; int lat, loads, oth, ac, prev_ac; logic [2:0] ls; logic [15:0] li; logic aa;
        for (int k = 0; k < 8; k++) begin
            v = 16'(16'h1111 * (k + 1));
            run_txn(1, 1'b1, 3'(k), v, rd, lat, loads, ls, li, oth, aa, ac);
            $display("p1 write addr=%0d data=%h lat=%0d rd=%h", k, v, lat, rd);
            total_cnt++;
            if (rd !== v || lat !== 2 || loads !== 1)
                $display("FAIL fill_write%0d got rd=%h lat=%0d loads=%0d exp %h/2/1", k, rd, lat, loads, v);
            else pass_cnt++;
        end
        prev_ac = 0;
        for (int k = 0; k < 8; k++) begin
            v = 16'(16'h1111 * (k + 1));
            run_txn(0, 1'b0, 3'(k), 16'h0, rd, lat, loads, ls, li, oth, aa, ac);
            $display("p0 read addr=%0d rd=%h ack_cycle=%0d", k, rd, ac);
            total_cnt++;
            if (rd !== v) $display("FAIL verify_read%0d got=%h exp=%h", k, rd, v); else pass_cnt++;
            if (k > 0) begin
                total_cnt++;
                if (ac - prev_ac !== 3) $display("FAIL ack_spacing%0d got=%0d exp=3", k, ac - prev_ac);
                else pass_cnt++;
            end
            prev_ac = ac;
        end
    endtask

    task automatic test_contention();
        int seq [0:15]; int nacks, both, max_wait, last0, last1;
        logic [15:0] rd0_seen, rd1_seen;
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd1; wdata0 = 16'h0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 16'hABCD;
        nacks = 0; both = 0; max_wait = 0; last0 = 0; last1 = 0; rd0_seen = '0; rd1_seen = '0;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            if (ack0 === 1'b1 && ack1 === 1'b1) both++;
            if (ack0 === 1'b1) begin
                if (nacks < 16) seq[nacks] = 0;
                nacks++; rd0_seen = rdata0;
                if (n - last0 > max_wait) max_wait = n - last0;
                last0 = n;
            end else if (ack1 === 1'b1) begin
                if (nacks < 16) seq[nacks] = 1;
                nacks++; rd1_seen = rdata1;
                if (n - last1 > max_wait) max_wait = n - last1;
                last1 = n;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int n = 0; n < 8 && busy !== 1'b0; n++) begin @(posedge clk); #1; end
        $display("contention acks=%0d both=%0d max_wait=%0d rd0=%h rd1=%h", nacks, both, max_wait, rd0_seen, rd1_seen);
        total_cnt++;
        if (nacks !== 8 || both !== 0) $display("FAIL contention_count got acks=%0d both=%0d exp 8/0", nacks, both);
        else pass_cnt++;
        total_cnt++;
        if (nacks < 4 || seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 0 || seq[3] !== 1)
            $display("FAIL contention_order got %0d%0d%0d%0d exp 0101", seq[0], seq[1], seq[2], seq[3]);
        else pass_cnt++;
        total_cnt++;
        if (max_wait > 6) $display("FAIL contention_wait got=%0d exp<=6", max_wait); else pass_cnt++;
        total_cnt++;
        if (rd0_seen !== 16'h2222 || rd1_seen !== 16'hABCD || mem[2] !== 16'hABCD)
            $display("FAIL contention_data got rd0=%h rd1=%h mem2=%h exp 2222/ABCD/ABCD", rd0_seen, rd1_seen, mem[2]);
        else pass_cnt++;
    endtask

    task automatic test_latching();
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd5; wdata0 = 16'h0;
        @(posedge clk); #1;
        addr0 = 3'd6; we0 = 1'b1; wdata0 = 16'hFFFF;
        total_cnt++;
        if (ram_sel !== 3'd5 || ram_load !== 1'b0)
            $display("FAIL latch_access got sel=%0d load=%b exp 5/0", ram_sel, ram_load);
        else pass_cnt++;
        @(posedge clk); #1;
        $display("latch: ack0=%b rdata0=%h sel=%0d", ack0, rdata0, ram_sel);
        total_cnt++;
        if (ack0 !== 1'b1 || rdata0 !== 16'h6666 || ram_sel !== 3'd5)
            $display("FAIL latch_resp got ack=%b rd=%h sel=%0d exp 1/6666/5", ack0, rdata0, ram_sel);
        else pass_cnt++;
        req0 = 1'b0; we0 = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (mem[6] !== 16'h7777) $display("FAIL latch_no_side_write got mem6=%h exp 7777", mem[6]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] rd; int lat, loads, oth, ac; logic [2:0] ls; logic [15:0] li; logic aa;
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd4; wdata1 = 16'hBEEF;
        @(posedge clk); #1;
        total_cnt++;
        if (ram_load !== 1'b1 || ram_sel !== 3'd4)
            $display("FAIL midrst_access got load=%b sel=%0d exp 1/4", ram_load, ram_sel);
        else pass_cnt++;
        rst_n = 1'b0; req1 = 1'b0; we1 = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (ram_load !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0)
            $display("FAIL midrst_abort got load=%b ack1=%b busy=%b exp 0/0/0", ram_load, ack1, busy);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (ack1 !== 1'b0) $display("FAIL midrst_no_ack got=%b exp=0", ack1); else pass_cnt++;
        run_txn(0, 1'b0, 3'd4, 16'h0, rd, lat, loads, ls, li, oth, aa, ac);
        $display("midrst: read addr=4 rd=%h lat=%0d", rd, lat);
        total_cnt++;
        if (rd !== 16'h5555 || lat !== 2) $display("FAIL midrst_prior_contents got rd=%h lat=%0d exp 5555/2", rd, lat);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        test_reset();
        test_p0_write_read();
        test_fill_verify();
        test_contention();
        test_latching();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
